// File: rtl/esi_mmio_regfile_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : EsiMmioPkg
// Purpose  : Shared types and constants for the ESI cosim MMIO responder.
//            Holds the AXI response code enum, the read FSM state enum, the
//            register-map stride / ID offset, and the decode result struct
//            produced by esi_mmio_addr_decode.
// Revision : 1.0 - initial release
// ============================================================================
package EsiMmioPkg;

  // Register map geometry: every mapped word is 64 bits wide.
  localparam int REG_STRIDE = 8;
  localparam int ID_OFFSET  = 0;

  // Index width covers reg indices 0..63 plus one extra word (error counter).
  localparam int IDX_W = 7;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  // idx is the register index (word - 1); it is only meaningful when is_id
  // is clear and resp is OKAY.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             is_id;
    resp_t            resp;
  } decode_t;

endpackage : EsiMmioPkg
`default_nettype wire

// File: rtl/esi_mmio_regfile_responder_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : esi_mmio_addr_decode
// Purpose  : Combinational byte-address decoder for the MMIO responder.
//            Maps an address to a register index and a response code.
//            Priority: misaligned -> SLVERR, out of map -> DECERR,
//            write to a read-only word -> SLVERR, otherwise OKAY.
// Ports    : addr_i     - byte address
//            is_write_i - 1 for the write path (enables RO checks)
//            dec_o      - {idx, is_id, resp}
// Config   : ESI_MMIO_ERR_COUNT_EN extends the map by one RO word.
// Revision : 1.0 - initial release
// ============================================================================
module esi_mmio_addr_decode
  import EsiMmioPkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [31:0] addr_i,
  input  logic        is_write_i,
  output decode_t     dec_o
);

`ifdef ESI_MMIO_ERR_COUNT_EN
  localparam int LAST_WORD = NUM_REGS + 1;
`else
  localparam int LAST_WORD = NUM_REGS;
`endif

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of
  // the map and decode as DECERR.
  logic [31:0] offset;
  logic [28:0] word;
  logic        is_id;
  logic        is_ro_extra;

  assign offset      = addr_i - BASE_ADDR;
  assign word        = offset[31:3];
  assign is_id       = (word == 29'(ID_OFFSET / REG_STRIDE));
  // Word NUM_REGS+1 is the error counter when present; without the feature
  // it is already past LAST_WORD and the DECERR branch wins.
  assign is_ro_extra = (word == 29'(NUM_REGS + 1));

  always_comb begin
    dec_o.idx   = word[IDX_W-1:0] - IDX_W'(1);
    dec_o.is_id = is_id;
    if (offset[2:0] != 3'b000) begin
      dec_o.resp = SLVERR;
    end else if (word > 29'(LAST_WORD)) begin
      dec_o.resp = DECERR;
    end else if (is_write_i && (is_id || is_ro_extra)) begin
      dec_o.resp = SLVERR;
    end else begin
      dec_o.resp = OKAY;
    end
  end

endmodule : esi_mmio_addr_decode
`default_nettype wire

// File: rtl/esi_mmio_regfile_responder.sv
`default_nettype none
// ============================================================================
// Module   : esi_mmio_regfile_responder
// Purpose  : AXI-lite MMIO responder (32-bit address, 64-bit data) for the
//            ESI cosim low-level interface. Serves a read-only ID word at
//            BASE_ADDR followed by NUM_REGS read/write 64-bit registers, and
//            exports register contents and per-register write pulses.
// Ports    : clk, rst_n (async, active-low)
//            ar*/r*     - read address / read data channels
//            aw*/w*/b*  - write address / write data / write response
//            regs       - register i at bits [64*i +: 64]
//            wr_pulse   - one-cycle pulse per register on an OKAY write
// Config   : ESI_MMIO_ERR_COUNT_EN adds a 16-bit saturating RO error
//            counter at offset 8*(NUM_REGS+1).
// Revision : 1.0 - initial release
// ============================================================================
module esi_mmio_regfile_responder
  import EsiMmioPkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [63:0] ID_VALUE  = 64'hE51C_0000_0000_0001
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [31:0]             araddr,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [63:0]             rdata,
  output logic [1:0]              rresp,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [31:0]             awaddr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [63:0]             wdata,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  output logic [64*NUM_REGS-1:0]  regs,
  output logic [NUM_REGS-1:0]     wr_pulse
);

  // --------------------------------------------------------------------------
  // Storage and decode
  // --------------------------------------------------------------------------
  logic [63:0] regs_q [NUM_REGS];
  decode_t     rd_dec;
  decode_t     wr_dec;

  esi_mmio_addr_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_rd_decode (
    .addr_i     (araddr),
    .is_write_i (1'b0),
    .dec_o      (rd_dec)
  );

  // Write address comes from the holding slot once latched.
  logic        aw_held_q;
  logic [31:0] awaddr_q;
  logic        w_held_q;
  logic [63:0] wdata_q;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;

  assign wr_addr = aw_held_q ? awaddr_q : awaddr;
  assign wr_data = w_held_q  ? wdata_q  : wdata;

  esi_mmio_addr_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_wr_decode (
    .addr_i     (wr_addr),
    .is_write_i (1'b1),
    .dec_o      (wr_dec)
  );

`ifdef ESI_MMIO_ERR_COUNT_EN
  logic [15:0] err_cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Read data selection (pre-write register values)
  // --------------------------------------------------------------------------
  logic [63:0] rd_data_d;

  always_comb begin
    rd_data_d = 64'd0;
    if (rd_dec.resp == OKAY) begin
      if (rd_dec.is_id) begin
        rd_data_d = ID_VALUE;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (rd_dec.idx == IDX_W'(i)) rd_data_d = regs_q[i];
        end
`ifdef ESI_MMIO_ERR_COUNT_EN
        if (rd_dec.idx == IDX_W'(NUM_REGS)) rd_data_d = {48'd0, err_cnt_q};
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  rd_state_t rd_state_q;
  logic      arready_q;
  logic      rvalid_q;
  logic [63:0] rdata_q;
  resp_t     rresp_q;
  logic      ar_fire;

  assign ar_fire = arvalid && arready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= 64'd0;
      rresp_q    <= OKAY;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_fire) begin
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_data_d;
            rresp_q    <= rd_dec.resp;
            rd_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // --------------------------------------------------------------------------
  // Write path: independent aw/w holding slots, commit when both available
  // --------------------------------------------------------------------------
  logic                bvalid_q;
  resp_t               bresp_q;
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic                awready_d;
  logic                wready_d;
  logic                aw_fire;
  logic                w_fire;
  logic                commit;
  logic                wr_en;
  logic [NUM_REGS-1:0] wr_onehot;

  assign awready_d = !aw_held_q && !bvalid_q;
  assign wready_d  = !w_held_q  && !bvalid_q;
  assign aw_fire   = awvalid && awready_d;
  assign w_fire    = wvalid  && wready_d;
  assign commit    = (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign wr_en     = commit && (wr_dec.resp == OKAY) && !wr_dec.is_id;

  always_comb begin
    wr_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_onehot[i] = (wr_dec.idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q  <= 1'b0;
      awaddr_q   <= 32'd0;
      w_held_q   <= 1'b0;
      wdata_q    <= 64'd0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= wr_en ? wr_onehot : '0;
      if (bvalid_q && bready) bvalid_q <= 1'b0;
      if (commit) begin
        // Slots are never held while bvalid is high, so commit and the
        // b handshake cannot coincide.
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_dec.resp;
      end else begin
        if (aw_fire) begin
          aw_held_q <= 1'b1;
          awaddr_q  <= awaddr;
        end
        if (w_fire) begin
          w_held_q <= 1'b1;
          wdata_q  <= wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 64'd0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && wr_onehot[i]) regs_q[i] <= wr_data;
      end
    end
  end

  assign awready  = awready_d;
  assign wready   = wready_d;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign wr_pulse = wr_pulse_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs[64*gi +: 64] = regs_q[gi];
  end

`ifdef ESI_MMIO_ERR_COUNT_EN
  // --------------------------------------------------------------------------
  // Error counter: counts error responses as they are issued; a read and a
  // write error issued on the same edge add 2.
  // --------------------------------------------------------------------------
  logic        r_err;
  logic        b_err;
  logic [16:0] err_sum;

  assign r_err   = ar_fire && (rd_dec.resp != OKAY);
  assign b_err   = commit  && (wr_dec.resp != OKAY);
  assign err_sum = {1'b0, err_cnt_q} + 17'(r_err) + 17'(b_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule : esi_mmio_regfile_responder
`default_nettype wire

// File: tb/tb_esi_mmio_regfile_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_esi_mmio_regfile_responder
// Purpose  : Self-checking bench for esi_mmio_regfile_responder. Directed
//            scenarios plus randomized reads/writes; expected responses come
//            from a behavioural register-map model and are queued, and a
//            monitor compares them as the DUT presents r/b responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_esi_mmio_regfile_responder;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [63:0] ID   = 64'hE51C_0000_0000_0001;
`ifdef ESI_MMIO_ERR_COUNT_EN
  localparam int LAST = N + 1;
`else
  localparam int LAST = N;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            arvalid, arready, rvalid, rready;
  logic [31:0]     araddr, awaddr;
  logic [63:0]     rdata, wdata;
  logic [1:0]      rresp, bresp;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic [64*N-1:0] regs;
  logic [N-1:0]    wr_pulse;

  esi_mmio_regfile_responder #(
    .NUM_REGS  (N),
    .BASE_ADDR (BASE),
    .ID_VALUE  (ID)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arvalid  (arvalid),
    .arready  (arready),
    .araddr   (araddr),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .rresp    (rresp),
    .awvalid  (awvalid),
    .awready  (awready),
    .awaddr   (awaddr),
    .wvalid   (wvalid),
    .wready   (wready),
    .wdata    (wdata),
    .bvalid   (bvalid),
    .bready   (bready),
    .bresp    (bresp),
    .regs     (regs),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard queues
  logic [63:0]  rq_d[$];
  logic [1:0]   rq_r[$];
  logic [1:0]   bq_r[$];
  logic [N-1:0] bq_p[$];

  // Reference model state
  logic [63:0] m_regs [N];
  int unsigned m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event-missing expected event at %0t", name, $time);
  endtask

  function automatic void model_read(input logic [31:0] a, output logic [63:0] d,
                                     output logic [1:0] r);
    logic [31:0] off;
    int unsigned w;
    off = a - BASE;
    w   = off / 8;
    d   = 64'd0;
    if (off % 8 != 0)       r = 2'b10;
    else if (w == 0)        begin r = 2'b00; d = ID; end
    else if (w <= N)        begin r = 2'b00; d = m_regs[w-1]; end
    else if (w <= LAST)     begin r = 2'b00; d = (m_err > 65535) ? 64'hFFFF : 64'(m_err); end
    else                    r = 2'b11;
    if (r != 2'b00) m_err++;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [63:0] d,
                                      output logic [1:0] r, output logic [N-1:0] p);
    logic [31:0] off;
    int unsigned w;
    off = a - BASE;
    w   = off / 8;
    p   = '0;
    if (off % 8 != 0)               r = 2'b10;
    else if (w > LAST)              r = 2'b11;
    else if (w == 0 || w == N + 1)  r = 2'b10;
    else begin
      r = 2'b00;
      m_regs[w-1] = d;
      p[w-1] = 1'b1;
    end
    if (r != 2'b00) m_err++;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0)      return BASE;
    else if (k <= 6) return BASE + 32'(8 * $urandom_range(1, N));
    else if (k == 7) return BASE + 32'(8 * $urandom_range(0, N)) + 32'($urandom_range(1, 7));
    else if (k == 8) return BASE + 32'(8 * (N + 1));
    else if ($urandom_range(0, 1) == 0) return BASE - 32'd8;
    else             return BASE + 32'(8 * $urandom_range(N + 2, N + 20));
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: compares responses at the cycle they are accepted
  // --------------------------------------------------------------------------
  initial begin : monitor
    logic bv_prev;
    bv_prev = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        bv_prev = 1'b0;
        continue;
      end
      if (bvalid && !bv_prev) begin
        if (bq_p.size() == 0) flag("b_unexpected");
        else chk("wr_pulse", 64'(wr_pulse), 64'(bq_p[0]));
      end else begin
        chk("wr_pulse_idle", 64'(wr_pulse), 64'd0);
      end
      if (rvalid && rready) begin
        if (rq_d.size() == 0) flag("r_unexpected");
        else begin
          chk("rdata", rdata, rq_d.pop_front());
          chk("rresp", 64'(rresp), 64'(rq_r.pop_front()));
        end
      end
      if (bvalid && bready) begin
        if (bq_r.size() == 0) flag("b_unexpected");
        else begin
          chk("bresp", 64'(bresp), 64'(bq_r.pop_front()));
          void'(bq_p.pop_front());
        end
      end
      bv_prev = bvalid;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Drivers (all start and end on a negedge)
  // --------------------------------------------------------------------------
  task automatic do_read(input logic [31:0] a, input int hold);
    int cyc;
    arvalid = 1'b1;
    araddr  = a;
    cyc     = 0;
    while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
    if (!arready) begin flag("ar_timeout"); arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_latency", 64'(rvalid), 64'd1);
    repeat (hold) begin
      chk("arready_busy", 64'(arready), 64'd0);
      chk("rvalid_held", 64'(rvalid), 64'd1);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rvalid_clear", 64'(rvalid), 64'd0);
    chk("arready_back", 64'(arready), 64'd1);
  endtask

  task automatic rd(input logic [31:0] a, input int hold);
    logic [63:0] d;
    logic [1:0]  r;
    model_read(a, d, r);
    rq_d.push_back(d);
    rq_r.push_back(r);
    do_read(a, hold);
  endtask

  task automatic drive_aw(input logic [31:0] a, input int dly);
    int cyc;
    repeat (dly) @(negedge clk);
    awvalid = 1'b1;
    awaddr  = a;
    cyc     = 0;
    while (!awready && cyc < 20) begin @(negedge clk); cyc++; end
    if (!awready) flag("aw_timeout");
    else @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [63:0] d, input int dly);
    int cyc;
    repeat (dly) @(negedge clk);
    wvalid = 1'b1;
    wdata  = d;
    cyc    = 0;
    while (!wready && cyc < 20) begin @(negedge clk); cyc++; end
    if (!wready) flag("w_timeout");
    else @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic finish_b(input int hold);
    chk("bvalid_latency", 64'(bvalid), 64'd1);
    repeat (hold) begin
      chk("awready_busy", 64'(awready), 64'd0);
      chk("wready_busy", 64'(wready), 64'd0);
      chk("bvalid_held", 64'(bvalid), 64'd1);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_clear", 64'(bvalid), 64'd0);
    chk("awready_back", 64'(awready), 64'd1);
    chk("wready_back", 64'(wready), 64'd1);
  endtask

  // mode 0: aw and w together, 1: aw leads by gap, 2: w leads by gap
  task automatic wr_drive(input logic [31:0] a, input logic [63:0] d,
                          input int mode, input int gap, input int hold);
    case (mode)
      1:       fork drive_aw(a, 0);   drive_w(d, gap); join
      2:       fork drive_aw(a, gap); drive_w(d, 0);   join
      default: fork drive_aw(a, 0);   drive_w(d, 0);   join
    endcase
    finish_b(hold);
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d,
                    input int mode, input int gap, input int hold);
    logic [1:0]   r;
    logic [N-1:0] p;
    model_write(a, d, r, p);
    bq_r.push_back(r);
    bq_p.push_back(p);
    wr_drive(a, d, mode, gap, hold);
  endtask

  task automatic check_regs();
    for (int i = 0; i < N; i++) chk("regs_out", regs[64*i +: 64], m_regs[i]);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : stim
    logic [63:0]  d;
    logic [1:0]   r;
    logic [N-1:0] p;
    rst_n   = 1'b0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; bready = 1'b0;
    for (int i = 0; i < N; i++) m_regs[i] = 64'd0;
    m_err = 0;
    #12;
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_wready",  64'(wready),  64'd1);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_bvalid",  64'(bvalid),  64'd0);
    chk("rst_rdata",   rdata,        64'd0);
    chk("rst_rresp",   64'(rresp),   64'd0);
    chk("rst_bresp",   64'(bresp),   64'd0);
    chk("rst_wr_pulse", 64'(wr_pulse), 64'd0);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ID read with rready held off for 3 cycles
    rd(BASE, 3);
    // Write reg 2 with aw three cycles ahead of w, then read back
    wr(BASE + 32'h18, 64'hDEAD_BEEF_0123_4567, 1, 3, 0);
    check_regs();
    rd(BASE + 32'h18, 0);
    // Simultaneous aw/w to reg 0, bready held off for 4 cycles
    wr(BASE + 32'h08, 64'h0123_4567_89AB_CDEF, 0, 0, 4);
    check_regs();
    // w before aw
    wr(BASE + 32'h20, 64'h5555_AAAA_5555_AAAA, 2, 2, 1);
    // Error decode
    rd(BASE + 32'h4, 1);
    rd(BASE + 32'(8 * (N + 2)), 0);
    wr(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    rd(BASE, 0);
    wr(BASE - 32'd8, 64'h1, 0, 0, 0);
    check_regs();

    // Same-edge read and write of reg 1: read sees the old value
    wr(BASE + 32'h10, 64'd5, 0, 0, 0);
    model_read(BASE + 32'h10, d, r);
    rq_d.push_back(d);
    rq_r.push_back(r);
    model_write(BASE + 32'h10, 64'd9, r, p);
    bq_r.push_back(r);
    bq_p.push_back(p);
    fork
      do_read(BASE + 32'h10, 0);
      wr_drive(BASE + 32'h10, 64'd9, 0, 0, 0);
    join
    rd(BASE + 32'h10, 0);
    check_regs();

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        rd(rand_addr(), int'($urandom_range(0, 3)));
      end else begin
        wr(rand_addr(), {$urandom(), $urandom()}, int'($urandom_range(0, 2)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        check_regs();
      end
    end

    // Reset with a pending read response and a held w beat
    arvalid = 1'b1;
    araddr  = BASE + 32'h8;
    @(negedge clk);
    arvalid = 1'b0;
    wvalid  = 1'b1;
    wdata   = 64'hCAFE_F00D_CAFE_F00D;
    @(negedge clk);
    wvalid  = 1'b0;
    chk("pre_rst_rvalid", 64'(rvalid), 64'd1);
    chk("pre_rst_wready", 64'(wready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
    chk("mid_rst_bvalid", 64'(bvalid), 64'd0);
    chk("mid_rst_wready", 64'(wready), 64'd1);
    for (int i = 0; i < N; i++) m_regs[i] = 64'd0;
    m_err = 0;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_rvalid", 64'(rvalid), 64'd0);
    // aw alone must not commit: the earlier w beat was discarded
    drive_aw(BASE + 32'h8, 0);
    repeat (4) begin
      chk("post_rst_no_b", 64'(bvalid), 64'd0);
      @(negedge clk);
    end
    model_write(BASE + 32'h8, 64'h77, r, p);
    bq_r.push_back(r);
    bq_p.push_back(p);
    drive_w(64'h77, 0);
    finish_b(0);
    check_regs();

    // Error counter after three errors (DECERR at that word when disabled)
    rd(BASE + 32'h3, 0);
    rd(BASE + 32'(8 * (N + 5)), 0);
    wr(BASE, 64'h2, 0, 0, 0);
    rd(BASE + 32'(8 * (N + 1)), 0);

    repeat (3) @(negedge clk);
    chk("rq_drained", 64'(rq_d.size()), 64'd0);
    chk("bq_drained", 64'(bq_r.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_esi_mmio_regfile_responder
`default_nettype wire
